pmc_reader: RTL

Read-out end of the PMC_unit counter interface. On a request it snapshots the four 256-bit performance counters (stall, CPI Q7.8, arithmetic, memory access) in one cycle. It then streams the snapshot as 32-bit words over a valid/ready handshake to the host/debug port. Sits between PMC_unit and the memory-mapped debug bridge.

---
 rtl/pmc_pkg.sv | 28 ++
 rtl/pmc_reader_if.sv | 24 ++
 rtl/pmc_word_sel.sv | 31 +++
 rtl/pmc_reader.sv | 86 ++++++++
 4 files changed

// File: rtl/pmc_pkg.sv
// Shared constants and types for the PMC counter read-out path.
// Define PMC_READER_HDR_EN to prepend a header word to every stream.
// Counter order on the stream follows pmc_cnt_e.
package pmc_pkg;

  localparam int CNT_W     = 256;
  localparam int WORD_W    = 32;
  localparam int NUM_CNT   = 4;
  localparam int WPC       = CNT_W / WORD_W;
  localparam int CNT_WORDS = NUM_CNT * WPC;

`ifdef PMC_READER_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  localparam int         TOTAL_WORDS = CNT_WORDS + HDR_WORDS;
  localparam logic [5:0] LAST_IDX    = 6'(TOTAL_WORDS - 1);

  localparam logic [15:0]       PMC_HDR_MAGIC = 16'hA5C3;
  localparam logic [WORD_W-1:0] PMC_HDR_WORD  = {PMC_HDR_MAGIC, 8'(NUM_CNT), 8'(WPC)};

  typedef enum logic [1:0] {STALL, CPI, ARITH, MEM} pmc_cnt_e;

  typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} pmc_rd_state_e;

endpackage

// File: rtl/pmc_reader_if.sv
// Word stream and status from the PMC reader to the debug bridge.
// master = reader side, slave = consumer side.
// out_ready is the only signal driven by the consumer.
interface pmc_reader_if;
  import pmc_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [5:0]        word_idx;

  modport master (
    output out_data, out_valid, busy, done, word_idx,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, busy, done, word_idx,
    output out_ready
  );

endinterface

// File: rtl/pmc_word_sel.sv
// Combinational mux from the shadow counters and word index to one output word.
// Zero latency; no backpressure of its own.
// With PMC_READER_HDR_EN defined, index 0 is the header and counters shift up by one.
module pmc_word_sel
  import pmc_pkg::*;
(
  input  logic [NUM_CNT*CNT_W-1:0] shadow,
  input  logic [5:0]               word_idx,
  output logic [WORD_W-1:0]        word
);

  logic [5:0] cnt_idx;

  // Counter 0 sits in the low bits, so word w is simply the w-th 32-bit slice.
  always_comb begin
    cnt_idx = word_idx - 6'(HDR_WORDS);
    word    = '0;
`ifdef PMC_READER_HDR_EN
    if (word_idx == 6'd0) begin
      word = PMC_HDR_WORD;
    end else if (cnt_idx < 6'(CNT_WORDS)) begin
      word = shadow[cnt_idx*WORD_W +: WORD_W];
    end
`else
    if (cnt_idx < 6'(CNT_WORDS)) begin
      word = shadow[cnt_idx*WORD_W +: WORD_W];
    end
`endif
  end

endmodule

// File: rtl/pmc_reader.sv
// Snapshots the four PMC counters on start, then streams them as 32-bit words.
// Latency: start -> first valid 2 cycles; full stream at 1 word/cycle -> done at TOTAL+3.
// Backpressure: word and index hold while out_valid && !out_ready; start ignored while busy.
module pmc_reader
  import pmc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] stall_count,
  input  logic [CNT_W-1:0] cycles_per_instruction_q78,
  input  logic [CNT_W-1:0] arith_count,
  input  logic [CNT_W-1:0] mem_access_count,
  pmc_reader_if.master     pmc
);

  pmc_rd_state_e                   state, state_nxt;
  logic [NUM_CNT-1:0][CNT_W-1:0]   shadow;
  logic [5:0]                      word_idx_q;
  logic                            done_q;
  logic [WORD_W-1:0]               sel_word;
  logic                            send_hs;

  assign send_hs = (state == SEND) && pmc.out_ready;

  pmc_word_sel u_word_sel (
    .shadow   (shadow),
    .word_idx (word_idx_q),
    .word     (sel_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one snapshot cycle, stream until the last handshake, one done cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SNAP;
      SNAP:    state_nxt = SEND;
      SEND:    if (send_hs && (word_idx_q == LAST_IDX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: valid only while sending; data forced to zero outside the stream.
  always_comb begin
    pmc.out_valid = (state == SEND);
    pmc.busy      = (state == SNAP) || (state == SEND);
    pmc.out_data  = (state == SEND) ? sel_word : '0;
    pmc.word_idx  = word_idx_q;
    pmc.done      = done_q;
  end

  // Shadow capture, word index advance and the done pulse following the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      word_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        SNAP: begin
          shadow[STALL] <= stall_count;
          shadow[CPI]   <= cycles_per_instruction_q78;
          shadow[ARITH] <= arith_count;
          shadow[MEM]   <= mem_access_count;
          word_idx_q    <= '0;
        end
        SEND: begin
          if (send_hs) begin
            word_idx_q <= (word_idx_q == LAST_IDX) ? 6'd0 : word_idx_q + 6'd1;
          end
        end
        DONE:    word_idx_q <= '0;
        default: ;
      endcase
    end
  end

endmodule
